// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path: frame state encoding
// and the supported oversampling ratios.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int unsigned PRESC_4  = 4;
    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;

    // Unsupported oversampling ratios fall back to 8x.
    function automatic int unsigned presc_norm(input int unsigned p);
        case (p)
            PRESC_4, PRESC_8, PRESC_16: return p;
            default:                    return PRESC_8;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Handshake between the RX frame controller and the RX datapath blocks
// (sampler, deserializer, start/parity/stop checkers).
interface uart_rx_fsm_if #(
    parameter int EDGE_W = 5
) ();
    // Checker results returned by the datapath.
    logic              strt_glitch;
    logic              par_err;
    logic              stp_err;

    // Counters, enables and frame qualification driven by the controller.
    logic [EDGE_W-1:0] edge_cnt;
    logic [3:0]        bit_cnt;
    logic              dat_samp_en;
    logic              deser_en;
    logic              strt_chk_en;
    logic              par_chk_en;
    logic              stp_chk_en;
    logic              data_valid;
    logic              par_error;
    logic              frame_error;

    modport master (
        input  strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, par_error, frame_error
    );

    modport slave (
        output strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en,
               data_valid, par_error, frame_error
    );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and data bit counter for the UART receiver.
// edge_cnt wraps at p_last (latched prescale minus 1); bit_cnt wraps after the last data bit.
module uart_rx_edge_bit_cnt #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_W     = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic              clr,
    input  logic              bit_en,
    input  logic [EDGE_W-1:0] p_last,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [3:0]        bit_cnt,
    output logic              last_edge
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    assign last_edge = en && (edge_cnt == p_last);

    // NOTE: counters are state, so they are updated with non-blocking
    // assignments; mixing in '=' here would make results depend on process order.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            edge_cnt <= last_edge ? '0 : edge_cnt + EDGE_W'(1);
            if (bit_en && last_edge)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, bit sequencing, checker
// strobes and per-frame qualification (data_valid, par_error, frame_error).
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 5,
    parameter int EDGE_W     = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               PAR_EN,
    uart_rx_fsm_if.master      rx_bus
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    rx_state_e         state;
    rx_state_e         state_nxt;
    logic [EDGE_W-1:0] p_last_q;
    logic              par_en_q;

    logic [EDGE_W-1:0] edge_cnt;
    logic [3:0]        bit_cnt;
    logic              last_edge;
    logic              pen_edge;

    logic dat_samp_en, deser_en;
    logic strt_chk_en, par_chk_en, stp_chk_en;
    logic data_valid, par_error, frame_error;

    uart_rx_edge_bit_cnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .EDGE_W     (EDGE_W)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .en        (state != ST_IDLE),
        .clr       (state == ST_IDLE),
        .bit_en    (state == ST_DATA),
        .p_last    (p_last_q),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    // Strobes are registered, so they are armed one edge before the last edge.
    assign pen_edge = (edge_cnt == p_last_q - EDGE_W'(1));

    // NOTE: state_nxt is given a default before the case so no path through
    // this block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!RX_IN) state_nxt = ST_START;
            ST_START:  if (last_edge) state_nxt = rx_bus.strt_glitch ? ST_IDLE : ST_DATA;
            ST_DATA:   if (last_edge && bit_cnt == LAST_BIT)
                           state_nxt = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (last_edge) state_nxt = ST_STOP;
            ST_STOP:   if (last_edge) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= ST_IDLE;
            p_last_q    <= EDGE_W'(PRESC_8 - 1);
            par_en_q    <= 1'b0;
            dat_samp_en <= 1'b0;
            deser_en    <= 1'b0;
            strt_chk_en <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            par_error   <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_IDLE && !RX_IN) begin
                p_last_q    <= EDGE_W'(presc_norm(32'(prescale)) - 32'd1);
                par_error   <= 1'b0;
                frame_error <= 1'b0;
            end
            if (state == ST_START && last_edge)
                par_en_q <= PAR_EN;
            if (state == ST_PARITY && last_edge)
                par_error <= rx_bus.par_err;
            if (state == ST_STOP && last_edge)
                frame_error <= rx_bus.stp_err;

            data_valid  <= (state == ST_STOP) && last_edge && !par_error && !rx_bus.stp_err;
            dat_samp_en <= (state_nxt != ST_IDLE);
            deser_en    <= (state_nxt == ST_DATA);
            strt_chk_en <= (state == ST_START)  && pen_edge;
            par_chk_en  <= (state == ST_PARITY) && pen_edge;
            stp_chk_en  <= (state == ST_STOP)   && pen_edge;
        end
    end

    assign rx_bus.edge_cnt    = edge_cnt;
    assign rx_bus.bit_cnt     = bit_cnt;
    assign rx_bus.dat_samp_en = dat_samp_en;
    assign rx_bus.deser_en    = deser_en;
    assign rx_bus.strt_chk_en = strt_chk_en;
    assign rx_bus.par_chk_en  = par_chk_en;
    assign rx_bus.stp_chk_en  = stp_chk_en;
    assign rx_bus.data_valid  = data_valid;
    assign rx_bus.par_error   = par_error;
    assign rx_bus.frame_error = frame_error;

endmodule
